// File: rtl/ctrl_store.sv
// ctrl_store: programmable decode control store.
// A 2^ADDR_W-entry table maps an instruction decode key to a control word.
// After reset a clear sweep invalidates every entry, one per cycle; only the
// valid bits are cleared, the stored words are left as they are. Lookups
// return the stored word, or ILL_CTRL plus an illegal flag for entries that
// were never programmed, one cycle after they are accepted.
module ctrl_store #(
    parameter int                 ADDR_W   = 11,
    parameter int                 CTRL_W   = 16,
    parameter logic [CTRL_W-1:0]  ILL_CTRL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              dec_valid,
    input  logic [ADDR_W-1:0] dec_addr,
    output logic              dec_ready,
    output logic              ctrl_valid,
    output logic [CTRL_W-1:0] ctrl_out,
    output logic              ctrl_illegal,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [CTRL_W-1:0] prog_data,
    output logic              prog_ack,
    output logic              init_busy,
    output logic [15:0]       ill_cnt
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {
        INIT,
        RUN
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] sweep_ptr;
    logic              sweep_last;
    logic              lookup_acc;
    logic              write_acc;
    logic              ctrl_valid_q;
    logic [CTRL_W-1:0] words [DEPTH];
    logic [DEPTH-1:0]  valid_bits;

    assign sweep_last = &sweep_ptr;
    assign lookup_acc = dec_valid & dec_ready;

    // State register: reset always restarts the clear sweep.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= INIT;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: leave INIT once the last entry has been cleared.
    always_comb begin
        state_nxt = state;
        case (state)
            INIT:    if (sweep_last) state_nxt = RUN;
            RUN:     state_nxt = RUN;
            default: state_nxt = INIT;
        endcase
    end

    // State outputs: writes win over lookups, and reset blocks both.
    always_comb begin
        init_busy = (state == INIT);
        dec_ready = (state == RUN) && !prog_we && !rst;
        write_acc = (state == RUN) && prog_we && !rst;
    end

    // Sweep pointer walks every entry once while in INIT.
    always_ff @(posedge clk) begin
        if (rst) begin
            sweep_ptr <= '0;
        end else if (state == INIT) begin
            sweep_ptr <= sweep_ptr + 1'b1;
        end
    end

    // Valid bits: cleared by the sweep, set by committed writes.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == INIT) begin
                valid_bits[sweep_ptr] <= 1'b0;
            end else if (write_acc) begin
                valid_bits[prog_addr] <= 1'b1;
            end
        end
    end

    // Control word storage, never cleared, only overwritten.
    always_ff @(posedge clk) begin
        if (write_acc) begin
            words[prog_addr] <= prog_data;
        end
    end

    // Lookup result, illegal counter and write acknowledge registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_valid_q <= 1'b0;
            ctrl_out     <= ILL_CTRL;
            ctrl_illegal <= 1'b0;
            ill_cnt      <= '0;
            prog_ack     <= 1'b0;
        end else begin
            ctrl_valid_q <= lookup_acc;
            prog_ack     <= write_acc;
            if (lookup_acc) begin
                if (valid_bits[dec_addr]) begin
                    ctrl_out     <= words[dec_addr];
                    ctrl_illegal <= 1'b0;
                end else begin
                    ctrl_out     <= ILL_CTRL;
                    ctrl_illegal <= 1'b1;
                    if (ill_cnt != 16'hFFFF) begin
                        ill_cnt <= ill_cnt + 16'd1;
                    end
                end
            end
        end
    end

    // A result pulse is suppressed as soon as reset is raised.
    assign ctrl_valid = ctrl_valid_q & ~rst;

endmodule

// File: tb/tb_ctrl_store.sv
// tb_ctrl_store: directed bench for ctrl_store with a behavioural model
// of the table, the init sweep length and the illegal-lookup counter.
module tb_ctrl_store;

    logic        clk = 1'b0;
    logic        rst;
    logic        dec_valid;
    logic [10:0] dec_addr;
    logic        dec_ready;
    logic        ctrl_valid;
    logic [15:0] ctrl_out;
    logic        ctrl_illegal;
    logic        prog_we;
    logic [10:0] prog_addr;
    logic [15:0] prog_data;
    logic        prog_ack;
    logic        init_busy;
    logic [15:0] ill_cnt;

    int tests = 0;
    int fails = 0;

    // Model state
    bit          model_live = 0;
    int          busy_left  = 0;
    logic [15:0] m_word  [2048];
    bit          m_valid [2048];
    bit          e_cv, e_ack, e_ill;
    logic [15:0] e_out;
    int          e_cnt;

    ctrl_store dut (
        .clk          (clk),
        .rst          (rst),
        .dec_valid    (dec_valid),
        .dec_addr     (dec_addr),
        .dec_ready    (dec_ready),
        .ctrl_valid   (ctrl_valid),
        .ctrl_out     (ctrl_out),
        .ctrl_illegal (ctrl_illegal),
        .prog_we      (prog_we),
        .prog_addr    (prog_addr),
        .prog_data    (prog_data),
        .prog_ack     (prog_ack),
        .init_busy    (init_busy),
        .ill_cnt      (ill_cnt)
    );

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    task automatic applyStimulus(input bit r, input bit pw, input logic [10:0] pa,
                                 input logic [15:0] pd, input bit dv, input logic [10:0] da);
        rst       = r;
        prog_we   = pw;
        prog_addr = pa;
        prog_data = pd;
        dec_valid = dv;
        dec_addr  = da;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        applyStimulus(0, 0, 11'h0, 16'h0, 0, 11'h0);
    endtask

    // Count busy cycles after a reset edge, bounded.
    task automatic waitSweep(input string name);
        int n = 0;
        while (init_busy === 1'b1 && n < 5000) begin
            n++;
            idle();
        end
        checkOutput(name, n, 2048);
    endtask

    // Behavioural model: advanced on each clock edge from the sampled inputs.
    always @(posedge clk) begin
        if (rst) begin
            model_live = 1;
            busy_left  = 2048;
            foreach (m_valid[i]) m_valid[i] = 0;
            e_cv  = 0;
            e_ack = 0;
            e_out = 16'h0000;
            e_ill = 0;
            e_cnt = 0;
        end else if (model_live) begin
            if (busy_left > 0) begin
                busy_left--;
                e_cv  = 0;
                e_ack = 0;
            end else begin
                e_ack = prog_we;
                e_cv  = dec_valid && !prog_we;
                if (prog_we) begin
                    m_word[prog_addr]  = prog_data;
                    m_valid[prog_addr] = 1;
                end else if (dec_valid) begin
                    if (m_valid[dec_addr]) begin
                        e_out = m_word[dec_addr];
                        e_ill = 0;
                    end else begin
                        e_out = 16'h0000;
                        e_ill = 1;
                        if (e_cnt < 65535) e_cnt++;
                    end
                end
            end
        end
    end

    // Compare every output against the model mid-cycle.
    always @(negedge clk) begin
        if (model_live) begin
            checkOutput("init_busy",    init_busy,    busy_left > 0);
            checkOutput("dec_ready",    dec_ready,    (busy_left == 0) && !prog_we && !rst);
            checkOutput("ctrl_valid",   ctrl_valid,   e_cv && !rst);
            checkOutput("prog_ack",     prog_ack,     e_ack);
            checkOutput("ctrl_out",     ctrl_out,     e_out);
            checkOutput("ctrl_illegal", ctrl_illegal, e_ill);
            checkOutput("ill_cnt",      ill_cnt,      e_cnt);
        end
    end

    // Directed sequence with hand-computed expectations.
    initial begin
        rst = 1; dec_valid = 0; dec_addr = '0; prog_we = 0; prog_addr = '0; prog_data = '0;

        // Reset pulse, reset values, then a full sweep.
        applyStimulus(1, 0, 11'h0, 16'h0, 0, 11'h0);
        applyStimulus(1, 0, 11'h0, 16'h0, 0, 11'h0);
        checkOutput("rst_ctrl_out", ctrl_out, 16'h0000);
        checkOutput("rst_ill_cnt", ill_cnt, 16'h0000);
        checkOutput("rst_busy", init_busy, 1);
        waitSweep("sweep_len_first");
        checkOutput("ready_after_init", dec_ready, 1);

        // Write then lookup.
        applyStimulus(0, 1, 11'h033, 16'h0040, 0, 11'h0);
        checkOutput("ack_033", prog_ack, 1);
        applyStimulus(0, 0, 11'h0, 16'h0, 1, 11'h033);
        checkOutput("lookup_033_valid", ctrl_valid, 1);
        checkOutput("lookup_033_out", ctrl_out, 16'h0040);
        checkOutput("lookup_033_ill", ctrl_illegal, 0);
        idle();
        checkOutput("hold_valid_low", ctrl_valid, 0);
        checkOutput("hold_out", ctrl_out, 16'h0040);

        // Illegal lookups and counter saturation.
        applyStimulus(0, 0, 11'h0, 16'h0, 1, 11'h7FF);
        checkOutput("ill_7ff_out", ctrl_out, 16'h0000);
        checkOutput("ill_7ff_flag", ctrl_illegal, 1);
        checkOutput("ill_cnt_one", ill_cnt, 16'h0001);
        for (int i = 0; i < 70000; i++) applyStimulus(0, 0, 11'h0, 16'h0, 1, 11'h7FF);
        checkOutput("ill_cnt_sat", ill_cnt, 16'hFFFF);

        // Write and lookup in the same cycle: the write wins.
        rst = 0; prog_we = 1; prog_addr = 11'h100; prog_data = 16'h1234;
        dec_valid = 1; dec_addr = 11'h100;
        #1;
        checkOutput("same_cycle_ready", dec_ready, 0);
        @(posedge clk); #1;
        checkOutput("same_cycle_ack", prog_ack, 1);
        checkOutput("same_cycle_no_valid", ctrl_valid, 0);
        applyStimulus(0, 0, 11'h0, 16'h0, 1, 11'h100);
        checkOutput("same_cycle_committed", ctrl_out, 16'h1234);

        // Rewrite followed by an immediate lookup.
        applyStimulus(0, 1, 11'h633, 16'h004A, 0, 11'h0);
        applyStimulus(0, 1, 11'h633, 16'h0055, 0, 11'h0);
        applyStimulus(0, 0, 11'h0, 16'h0, 1, 11'h633);
        checkOutput("rewrite_out", ctrl_out, 16'h0055);

        // Lookup accepted just before reset produces no pulse.
        applyStimulus(0, 0, 11'h0, 16'h0, 1, 11'h033);
        rst = 1; dec_valid = 0;
        #1;
        checkOutput("pre_rst_no_valid", ctrl_valid, 0);
        @(posedge clk); #1;

        // Mid-sweep reset at cycle 1000; INIT ignores writes and lookups.
        for (int i = 0; i < 1000; i++) applyStimulus(0, i[0], 11'h033, 16'hBEEF, 1, 11'h033);
        applyStimulus(1, 0, 11'h0, 16'h0, 0, 11'h0);
        waitSweep("sweep_len_restart");
        applyStimulus(0, 0, 11'h0, 16'h0, 1, 11'h033);
        checkOutput("after_rst_033_ill", ctrl_illegal, 1);
        checkOutput("after_rst_033_out", ctrl_out, 16'h0000);
        checkOutput("after_rst_cnt", ill_cnt, 16'h0001);
        idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
